uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
- Serial asynchronous transmitter with an integrated baud-rate divider. All logic runs on one reference clock.
- Frames an 8-bit byte as: start bit, 8 data bits LSB first, one parity bit (odd or even), two stop bits.
- Sits between the host logic (data_in/transmit) and the TX line pin (serial_out).

Parameters:
- CLK_FREQ, 150000, reference clock frequency in Hz.
- BAUD, 300, line bit rate in bits/s.
- DIV, CLK_FREQ/BAUD (=500), ref_clk cycles per bit. Must be >= 2.

Ports:
- ref_clk, input, 1, reference clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- parity, input, 1, parity mode: 0 = odd, 1 = even. Sampled when a request is accepted.
- transmit, input, 1, transmit request; level-sensitive, sampled in IDLE.
- data_in, input, 8, byte to send. Sampled when a request is accepted.
- serial_out, output, 1, TX line; idles high.
- tx_done, output, 1, one-cycle pulse when a frame completes.

Behaviour:
- Baud generator:
  - Free-running counter 0..DIV-1; reset clears it to 0.
  - A baud tick is asserted for one ref_clk cycle when the counter equals DIV-1; the counter then wraps to 0.
  - The counter never restarts on a request.
- Reset (async, immediate): state = IDLE, serial_out = 1, tx_done = 0, shift register = 0, bit counter = 0, pending = 0.
- States: IDLE, PEND, START, DATA, PAR, STOP1, STOP2.
- IDLE:
  - serial_out = 1.
  - If transmit = 1 on a clock edge: latch data_in into the shift register, latch the parity bit, go to PEND.
  - The latched parity bit is computed as: odd mode = ~^data_in; even mode = ^data_in.
  - A request is accepted even if transmit is high for only one ref_clk cycle.
- PEND: serial_out = 1; on the next baud tick go to START. Latency from acceptance to the start-bit edge is 1..DIV cycles.
- START: serial_out = 0 for one bit period (tick to tick), then DATA.
- DATA:
  - serial_out = shift[0]; shift right on each tick.
  - Exactly 8 bits, counted 0..7; after the 8th tick go to PAR.
- PAR: serial_out = latched parity bit for one bit period, then STOP1.
- STOP1, STOP2: serial_out = 1 for one bit period each.
- Frame end: on the tick ending STOP2, tx_done = 1 for exactly that one ref_clk cycle and state returns to IDLE.
- Every bit lasts exactly DIV ref_clk cycles. A full frame is 12 bit periods.
- Back-to-back: if transmit is still high in IDLE right after completion, a new frame is accepted on that edge.
- transmit, data_in and parity are ignored outside IDLE; changing them mid-frame does not affect the frame in flight.
- Reset mid-frame aborts immediately: serial_out returns high and no tx_done pulse is generated.
- serial_out is driven from a register (glitch-free).

Optional Feature:
- Macro TX_BUSY_EN.
- Defined: adds output port tx_busy (1 bit). tx_busy = 1 in every state except IDLE, 0 in reset and IDLE. It rises the cycle after acceptance and falls in the same cycle as tx_done.
- Undefined: the port does not exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset for 3 cycles -> serial_out = 1 and tx_done = 0 during and after reset, with no activity while transmit = 0.
- Odd parity: parity = 0, data_in = 8'b10110011, transmit pulsed for 1 cycle -> serial_out bits (each 500 cycles) = 0 | 1 1 0 0 1 1 0 1 | 0 | 1 1; a single tx_done pulse at the end of the second stop bit.
- Even parity: parity = 1, same data -> 0 | 1 1 0 0 1 1 0 1 | 1 | 1 1.
- Edge data: data_in = 8'h00 with odd parity -> parity bit = 1; data_in = 8'hFF with even parity -> parity bit = 0. Frame length exactly 6000 cycles from start-bit edge to return to idle.
- Mid-frame changes: change data_in/parity and re-pulse transmit during DATA -> the frame is unchanged and no extra frame is sent. Holding transmit high continuously -> back-to-back frames with no idle bit time between STOP2 and the next PEND.
- Reset during DATA -> serial_out = 1 immediately, no tx_done pulse. The next request produces a correct full frame.

Source files
------------

// File: rtl/uart_tx_core_if.sv
// Host-side bundle for uart_tx_core: request/data/parity in, line and completion out.
// master = host logic driving requests; slave = the transmitter core.
// Optional port tx_busy exists only when TX_BUSY_EN is defined.
//
// Signals:
//   parity     host->core  parity mode (0 = odd, 1 = even), sampled on accept
//   transmit   host->core  level-sensitive transmit request, sampled in IDLE
//   data_in    host->core  byte to send, sampled on accept
//   serial_out core->host  TX line, idles high
//   tx_done    core->host  one-cycle pulse at frame completion
//   tx_busy    core->host  high while a frame is pending or in flight (TX_BUSY_EN)
interface uart_tx_core_if;
   logic       parity;
   logic       transmit;
   logic [7:0] data_in;
   logic       serial_out;
   logic       tx_done;
`ifdef TX_BUSY_EN
   logic       tx_busy;

   modport master (
      output parity,
      output transmit,
      output data_in,
      input  serial_out,
      input  tx_done,
      input  tx_busy
   );

   modport slave (
      input  parity,
      input  transmit,
      input  data_in,
      output serial_out,
      output tx_done,
      output tx_busy
   );
`else
   modport master (
      output parity,
      output transmit,
      output data_in,
      input  serial_out,
      input  tx_done
   );

   modport slave (
      input  parity,
      input  transmit,
      input  data_in,
      output serial_out,
      output tx_done
   );
`endif
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter with built-in baud divider: start, 8 data LSB-first, parity, 2 stop bits.
// Latency: start-bit edge 1..DIV ref_clk cycles after a request is accepted; frame = 12*DIV cycles.
// Backpressure: requests are only sampled in IDLE; transmit/data_in/parity are ignored mid-frame.
//
// Optional feature macro: TX_BUSY_EN (adds bus.tx_busy).
//
// Ports:
//   ref_clk  reference clock, all state updates on the rising edge
//   reset    asynchronous active-high reset
//   bus      uart_tx_core_if.slave (parity, transmit, data_in, serial_out, tx_done[, tx_busy])
//
// Parameters:
//   CLK_FREQ reference clock frequency in Hz
//   BAUD     line bit rate in bits/s
//   DIV      ref_clk cycles per bit (CLK_FREQ/BAUD), must be >= 2
module uart_tx_core #(
   parameter int CLK_FREQ = 150000,
   parameter int BAUD     = 300,
   parameter int DIV      = CLK_FREQ / BAUD
) (
   input  logic           ref_clk,
   input  logic           reset,
   uart_tx_core_if.slave  bus
);

   // Counter width; guarded so a degenerate DIV still elaborates.
   localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PEND,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP1,
      S_STOP2
   } state_t;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t        r_state;
   state_t        w_state_nxt;

   logic [CW-1:0] r_baud_cnt;
   logic          w_tick;

   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;

   logic [2:0]    r_bit_cnt;
   logic [2:0]    w_bit_cnt_nxt;

   logic          r_par_bit;
   logic          w_par_bit_nxt;

   logic          r_serial_out;
   logic          w_serial_nxt;

   logic          r_tx_done;
   logic          w_tx_done_nxt;

   // ------------------------------------------------------------------
   // Baud generator: free-running, never re-aligned to a request. That
   // is why a new frame waits in PEND for the next tick, giving the
   // 1..DIV cycle acceptance-to-start latency.
   // ------------------------------------------------------------------
   assign w_tick = (r_baud_cnt == C_LAST);

   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         r_baud_cnt <= '0;
      end else if (w_tick) begin
         r_baud_cnt <= '0;
      end else begin
         r_baud_cnt <= r_baud_cnt + CW'(1);
      end
   end

   // ------------------------------------------------------------------
   // FSM state and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_shift      <= '0;
         r_bit_cnt    <= '0;
         r_par_bit    <= 1'b0;
         r_serial_out <= 1'b1;
         r_tx_done    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_par_bit    <= w_par_bit_nxt;
         r_serial_out <= w_serial_nxt;
         r_tx_done    <= w_tx_done_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_par_bit_nxt = r_par_bit;
      w_tx_done_nxt = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (bus.transmit) begin
               w_shift_nxt   = bus.data_in;
               // Odd mode: bit makes total ones odd; even mode: makes it even.
               w_par_bit_nxt = bus.parity ? (^bus.data_in) : (~^bus.data_in);
               w_bit_cnt_nxt = 3'd0;
               w_state_nxt   = S_PEND;
            end
         end
         S_PEND: begin
            if (w_tick) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_bit_cnt_nxt = 3'd0;
               w_state_nxt   = S_DATA;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift_nxt = {1'b0, r_shift[7:1]};
               if (r_bit_cnt == 3'd7) begin
                  w_bit_cnt_nxt = 3'd0;
                  w_state_nxt   = S_PAR;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         S_PAR: begin
            if (w_tick) begin
               w_state_nxt = S_STOP1;
            end
         end
         S_STOP1: begin
            if (w_tick) begin
               w_state_nxt = S_STOP2;
            end
         end
         S_STOP2: begin
            if (w_tick) begin
               w_tx_done_nxt = 1'b1;
               w_state_nxt   = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // The line level is derived from the *next* state so the registered
   // serial_out changes on the same edge as the state, with no extra
   // cycle of skew between FSM and pin.
   always_comb begin
      w_serial_nxt = 1'b1;
      unique case (w_state_nxt)
         S_START: w_serial_nxt = 1'b0;
         S_DATA:  w_serial_nxt = w_shift_nxt[0];
         S_PAR:   w_serial_nxt = w_par_bit_nxt;
         default: w_serial_nxt = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.serial_out = r_serial_out;
   assign bus.tx_done    = r_tx_done;

`ifdef TX_BUSY_EN
   // Falls on the same edge that raises tx_done since both follow the
   // STOP2 -> IDLE transition.
   assign bus.tx_busy = (r_state != S_IDLE);
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: scoreboard of expected 12-bit frames,
// a line monitor that decodes frames mid-bit and checks length and tx_done.
module tb_uart_tx_core;

   localparam int CLK_FREQ = 150000;
   localparam int BAUD     = 300;
   localparam int DIV      = 500;

   logic ref_clk;
   logic reset;

   uart_tx_core_if bus ();

   uart_tx_core #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .DIV      (DIV)
   ) dut (
      .ref_clk (ref_clk),
      .reset   (reset),
      .bus     (bus)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int last_start_cyc = 0;
   logic [11:0] sb[$];

   // Frame vector: [0]=start, [8:1]=data LSB first, [9]=parity, [11:10]=stops.
   function automatic logic [11:0] make_frame(input logic [7:0] d, input logic p);
      logic pb;
      pb = p ? (^d) : (~^d);
      return {2'b11, pb, d, 1'b0};
   endfunction

   always @(posedge ref_clk) cyc <= cyc + 1;

   always @(negedge ref_clk) begin
      if (!reset && bus.tx_done) done_cnt <= done_cnt + 1;
   end

   // ------------------------------------------------------------------
   // Line monitor
   // ------------------------------------------------------------------
   logic        m_prev;
   logic [11:0] m_got;
   logic [11:0] m_exp;
   int          m_t0;
   bit          m_abort;
   bit          m_busy;

   initial begin
      m_prev = 1'b1;
      m_busy = 1'b0;
      forever begin
         @(negedge ref_clk);
         if (reset) begin
            m_prev = 1'b1;
         end else if (m_prev && !bus.serial_out) begin
            m_busy  = 1'b1;
            m_t0    = cyc;
            last_start_cyc = cyc;
            m_got   = '0;
            m_abort = 1'b0;
            for (int b = 0; b < 12; b++) begin
               while (!reset && cyc < m_t0 + b * DIV + DIV / 2) @(negedge ref_clk);
               if (reset) begin
                  m_abort = 1'b1;
                  break;
               end
               m_got[b] = bus.serial_out;
            end
            if (!m_abort) begin
               while (!reset && !bus.tx_done && cyc < m_t0 + 13 * DIV) @(negedge ref_clk);
               if (reset) m_abort = 1'b1;
            end
            if (m_abort) begin
               if (sb.size() > 0) void'(sb.pop_front());
               m_prev = 1'b1;
            end else begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL frame_spurious: got frame %b, required no frame", m_got);
               end else begin
                  m_exp = sb.pop_front();
                  if (m_got !== m_exp) begin
                     errors++;
                     $display("FAIL frame_bits: got %b, required %b", m_got, m_exp);
                  end
               end
               checks++;
               if (bus.tx_done !== 1'b1 || cyc - m_t0 != 12 * DIV) begin
                  errors++;
                  $display("FAIL frame_length: tx_done=%b after %0d cycles, required 1 after %0d",
                           bus.tx_done, cyc - m_t0, 12 * DIV);
               end
               m_prev = bus.serial_out;
            end
            m_busy = 1'b0;
         end else begin
            m_prev = bus.serial_out;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (no comparisons inside)
   // ------------------------------------------------------------------
   task automatic send(input logic [7:0] d, input logic p, output int acc);
      @(negedge ref_clk);
      bus.data_in  = d;
      bus.parity   = p;
      bus.transmit = 1'b1;
      acc = cyc + 1;
      @(negedge ref_clk);
      bus.transmit = 1'b0;
   endtask

   task automatic wait_frames(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge ref_clk);
         if (sb.size() == 0 && done_cnt == exp_done && !m_busy && bus.serial_out) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge ref_clk);
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge ref_clk);
         if (!bus.serial_out) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      bit bad;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ref_clk);
         checks++;
         if (bus.serial_out !== 1'b1 || bus.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: serial_out=%b tx_done=%b, required 1/0",
                     bus.serial_out, bus.tx_done);
         end
      end
      reset = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 2 * DIV; i++) begin
         @(negedge ref_clk);
         if (bus.serial_out !== 1'b1 || bus.tx_done !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_idle: line activity seen with transmit=0, required none");
      end
   endtask

   task automatic test_odd_parity();
      int acc;
      bit ok;
      sb.push_back(12'b110101100110);
      exp_done++;
      send(8'b10110011, 1'b0, acc);
`ifdef TX_BUSY_EN
      checks++;
      if (bus.tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise: tx_busy=%b, required 1", bus.tx_busy);
      end
`endif
      wait_frames(14 * DIV, ok);
      checks++;
      if (!ok || done_cnt !== exp_done) begin
         errors++;
         $display("FAIL odd_done: tx_done count %0d, required %0d", done_cnt, exp_done);
      end
      checks++;
      if (last_start_cyc - acc < 1 || last_start_cyc - acc > DIV) begin
         errors++;
         $display("FAIL odd_latency: %0d cycles, required 1..%0d", last_start_cyc - acc, DIV);
      end
   endtask

   task automatic test_even_parity();
      int acc;
      bit ok;
      sb.push_back(12'b111101100110);
      exp_done++;
      send(8'b10110011, 1'b1, acc);
      wait_frames(14 * DIV, ok);
      checks++;
      if (!ok || done_cnt !== exp_done) begin
         errors++;
         $display("FAIL even_done: tx_done count %0d, required %0d", done_cnt, exp_done);
      end
   endtask

   task automatic test_edge_data();
      int acc;
      bit ok;
      sb.push_back(12'b111000000000);
      exp_done++;
      send(8'h00, 1'b0, acc);
      wait_frames(14 * DIV, ok);
      checks++;
      if (!ok || done_cnt !== exp_done) begin
         errors++;
         $display("FAIL edge00_done: tx_done count %0d, required %0d", done_cnt, exp_done);
      end
      sb.push_back(12'b110111111110);
      exp_done++;
      send(8'hFF, 1'b1, acc);
      wait_frames(14 * DIV, ok);
      checks++;
      if (!ok || done_cnt !== exp_done) begin
         errors++;
         $display("FAIL edgeFF_done: tx_done count %0d, required %0d", done_cnt, exp_done);
      end
   endtask

   task automatic test_midframe();
      int acc;
      bit ok;
      sb.push_back(make_frame(8'h5A, 1'b0));
      exp_done++;
      send(8'h5A, 1'b0, acc);
      wait_start(2 * DIV, ok);
      repeat (3 * DIV) @(negedge ref_clk);
      bus.data_in  = 8'hFF;
      bus.parity   = 1'b1;
      bus.transmit = 1'b1;
      @(negedge ref_clk);
      bus.transmit = 1'b0;
      wait_frames(14 * DIV, ok);
      repeat (2 * DIV) @(negedge ref_clk);
      checks++;
      if (!ok || sb.size() != 0 || done_cnt !== exp_done || m_busy) begin
         errors++;
         $display("FAIL midframe: tx_done count %0d pending %0d, required %0d and 0",
                  done_cnt, sb.size(), exp_done);
      end
   endtask

   task automatic test_back_to_back();
      int d_cyc;
      bit ok;
      sb.push_back(make_frame(8'h3C, 1'b0));
      sb.push_back(make_frame(8'h3C, 1'b0));
      exp_done += 2;
      @(negedge ref_clk);
      bus.data_in  = 8'h3C;
      bus.parity   = 1'b0;
      bus.transmit = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 14 * DIV; i++) begin
         @(negedge ref_clk);
         if (bus.tx_done) begin
            ok = 1'b1;
            break;
         end
      end
      d_cyc = cyc;
      @(negedge ref_clk);
      bus.transmit = 1'b0;
      if (ok) wait_start(2 * DIV, ok);
      checks++;
      if (!ok || cyc - d_cyc != DIV) begin
         errors++;
         $display("FAIL b2b_gap: %0d cycles from tx_done to next start, required %0d",
                  cyc - d_cyc, DIV);
      end
      wait_frames(14 * DIV, ok);
      checks++;
      if (!ok || done_cnt !== exp_done) begin
         errors++;
         $display("FAIL b2b_done: tx_done count %0d, required %0d", done_cnt, exp_done);
      end
   endtask

   task automatic test_reset_mid();
      int acc;
      bit ok;
      sb.push_back(make_frame(8'hC5, 1'b1));
      send(8'hC5, 1'b1, acc);
      wait_start(2 * DIV, ok);
      repeat (3 * DIV) @(negedge ref_clk);
      reset = 1'b1;
      #1;
      checks++;
      if (bus.serial_out !== 1'b1 || bus.tx_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_line: serial_out=%b tx_done=%b, required 1/0",
                  bus.serial_out, bus.tx_done);
      end
      repeat (3) @(negedge ref_clk);
      reset = 1'b0;
      repeat (5) @(negedge ref_clk);
      checks++;
      if (sb.size() != 0 || done_cnt !== exp_done) begin
         errors++;
         $display("FAIL reset_mid_abort: tx_done count %0d pending %0d, required %0d and 0",
                  done_cnt, sb.size(), exp_done);
      end
      sb.push_back(make_frame(8'hC5, 1'b1));
      exp_done++;
      send(8'hC5, 1'b1, acc);
      wait_frames(14 * DIV, ok);
      checks++;
      if (!ok || done_cnt !== exp_done) begin
         errors++;
         $display("FAIL reset_recover: tx_done count %0d, required %0d", done_cnt, exp_done);
      end
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      reset        = 1'b0;
      bus.transmit = 1'b0;
      bus.parity   = 1'b0;
      bus.data_in  = 8'h00;
      #2;
      test_reset();
      test_odd_parity();
      test_even_parity();
      test_edge_data();
      test_midframe();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
